rr_select4: RTL

RR_SELECT4 -- requirements
Module: rr_select4

---
 rtl/rr_select4.sv | 115 +++++++++++
 1 files changed

// File: rtl/rr_select4.sv
// Round-robin controller for a 4:1 mux: grants one requesting channel at a time
// for up to BURST transfers, then rotates to the next requester without a bubble.
module rr_select4 #(
  parameter int unsigned BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_valid,
  output logic [3:0] req_ready,
  output logic [1:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       grant_active
);

  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [1:0]      sel_n;
  logic [1:0]      last, last_n;
  logic [CW-1:0]   cnt, cnt_n;

  logic            xfer;
  logic            burst_done;
  logic            release_now;
  logic [1:0]      search_base;
  logic            win_found;
  logic [1:0]      win_idx;

  // Search last+1, last+2, last+3, last; k=4 wraps back to the base itself,
  // which is what lets a lone requester be re-granted after a full burst.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] pick;
    found = 1'b0;
    pick  = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  // While granted, last always equals sel; using sel directly keeps the
  // re-arbitration base obviously tied to the channel being released.
  assign search_base          = (state == GRANT) ? sel : last;
  assign {win_found, win_idx} = rr_pick(req_valid, search_base);

  assign xfer        = (state == GRANT) && req_valid[sel] && out_ready;
  assign burst_done  = xfer && ((cnt + CW'(1)) == CW'(BURST));
  assign release_now = burst_done || !req_valid[sel];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_n = state;
    sel_n   = sel;
    last_n  = last;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          state_n = GRANT;
          sel_n   = win_idx;
          last_n  = win_idx;
          cnt_n   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          cnt_n = '0;
          if (win_found) begin
            sel_n  = win_idx;
            last_n = win_idx;
          end else begin
            state_n = IDLE;
          end
        end else if (xfer) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'b00;
      last  <= 2'b11;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs decode from registered state/sel plus live inputs; reset forces IDLE,
  // so they drop immediately when rst_n falls.
  assign grant_active = (state == GRANT);
  assign out_valid    = grant_active && req_valid[sel];
  assign req_ready    = grant_active ? ({3'b000, out_ready} << sel) : 4'b0000;

endmodule
